// File: rtl/mh_accept.sv
// mh_accept: Metropolis-Hastings style accept/reject unit.
// Decimates an LFSR stream into a small FIFO of random words and, on each
// request handshake, compares the head word against the request's
// probability threshold. The registered result is held until the consumer
// takes it.
// Optional feature macro: MH_ACCEPT_STATS_EN enables the request/accept
// statistics counters. When it is undefined both counters are tied to 0.
module mh_accept #(
   parameter int NUM_BITS = 32,
   parameter int DEPTH    = 8,
   parameter int DECIM    = 4
) (
   input  logic                       i_Clk,
   input  logic                       i_Rst,
   input  logic [NUM_BITS-1:0]        i_LFSR_Data,
   input  logic                       i_LFSR_Valid,
   input  logic                       i_Req_Valid,
   input  logic [NUM_BITS-1:0]        i_Req_Prob,
   output logic                       o_Req_Ready,
   output logic                       o_Acc_Valid,
   input  logic                       i_Acc_Ready,
   output logic                       o_Accept,
   output logic [NUM_BITS-1:0]        o_Rand,
   output logic [$clog2(DEPTH):0]     o_Fifo_Count,
   output logic [31:0]                o_Req_Cnt,
   output logic [31:0]                o_Acc_Cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

   logic [NUM_BITS-1:0] mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]         count_q, count_d;
   logic [DW-1:0]       dec_q, dec_d;
   logic                acc_valid_q, acc_valid_d;
   logic                accept_q, accept_d;
   logic [NUM_BITS-1:0] rand_q, rand_d;

   logic                sample_wrap;
   logic                fifo_full;
   logic                req_ready;
   logic                pop;
   logic                push;
   logic [NUM_BITS-1:0] head_word;

   // Handshake and FIFO control decisions for the current cycle.
   always_comb begin
      sample_wrap = i_LFSR_Valid && (dec_q == DW'(DECIM - 1));
      fifo_full   = (count_q == (AW + 1)'(DEPTH));
      req_ready   = (count_q != '0) && (!acc_valid_q || i_Acc_Ready);
      pop         = i_Req_Valid && req_ready;
      // A full FIFO still accepts a sample when the head leaves the same cycle.
      push        = sample_wrap && (!fifo_full || pop) && !i_Rst;
      head_word   = mem_q[rd_ptr_q];
   end

   // Next-state for decimation counter, FIFO pointers/count and result.
   always_comb begin
      // NOTE: every always_comb target gets a default first so no path leaves it unassigned, which would infer a latch.
      dec_d       = dec_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      acc_valid_d = acc_valid_q;
      accept_d    = accept_q;
      rand_d      = rand_q;

      if (sample_wrap) begin
         dec_d = '0;
      end else if (i_LFSR_Valid) begin
         dec_d = dec_q + DW'(1);
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + (AW + 1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (AW + 1)'(1);
      end

      if (pop) begin
         acc_valid_d = 1'b1;
         accept_d    = (head_word < i_Req_Prob);
         rand_d      = head_word;
      end else if (i_Acc_Ready) begin
         acc_valid_d = 1'b0;
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (i_Rst) begin
         dec_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         acc_valid_q <= 1'b0;
         accept_q    <= 1'b0;
         rand_q      <= '0;
      end else begin
         dec_q       <= dec_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         acc_valid_q <= acc_valid_d;
         accept_q    <= accept_d;
         rand_q      <= rand_d;
      end
   end

   // FIFO storage write port.
   always_ff @(posedge i_Clk) begin
      // NOTE: the storage array is not reset; clearing the pointers and count already marks every entry invalid.
      if (push) begin
         mem_q[wr_ptr_q] <= i_LFSR_Data;
      end
   end

`ifdef MH_ACCEPT_STATS_EN
   logic [31:0] req_cnt_q, req_cnt_d;
   logic [31:0] acc_cnt_q, acc_cnt_d;

   // Statistics: count handshakes and accepted handshakes, wrapping at 2^32.
   always_comb begin
      req_cnt_d = req_cnt_q;
      acc_cnt_d = acc_cnt_q;
      if (pop) begin
         req_cnt_d = req_cnt_q + 32'd1;
         if (head_word < i_Req_Prob) begin
            acc_cnt_d = acc_cnt_q + 32'd1;
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         req_cnt_q <= '0;
         acc_cnt_q <= '0;
      end else begin
         req_cnt_q <= req_cnt_d;
         acc_cnt_q <= acc_cnt_d;
      end
   end

   assign o_Req_Cnt = req_cnt_q;
   assign o_Acc_Cnt = acc_cnt_q;
`else
   assign o_Req_Cnt = 32'd0;
   assign o_Acc_Cnt = 32'd0;
`endif

   assign o_Req_Ready  = req_ready;
   assign o_Acc_Valid  = acc_valid_q;
   assign o_Accept     = accept_q;
   assign o_Rand       = rand_q;
   assign o_Fifo_Count = count_q;

endmodule
